// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS main control: opcodes, state codes,
// datapath mux selects and the decoded control word.
package mips_pkg;

   // Opcodes recognised by the decoder (instr[31:26]).
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // FSM state codes; these values appear on state_o.
   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_DECODE  = 4'd1;
   localparam logic [3:0] S_MEMADR  = 4'd2;
   localparam logic [3:0] S_MEMRD   = 4'd3;
   localparam logic [3:0] S_MEMWB   = 4'd4;
   localparam logic [3:0] S_MEMWR   = 4'd5;
   localparam logic [3:0] S_RTYPEEX = 4'd6;
   localparam logic [3:0] S_RTYPEWB = 4'd7;
   localparam logic [3:0] S_BEQEX   = 4'd8;
   localparam logic [3:0] S_ADDIEX  = 4'd9;
   localparam logic [3:0] S_ADDIWB  = 4'd10;
   localparam logic [3:0] S_JEX     = 4'd11;
   localparam logic [3:0] S_HALT    = 4'd12;

   // ALU decoder operation requests.
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ALU B operand selects.
   localparam logic [1:0] ALUB_REG   = 2'b00;
   localparam logic [1:0] ALUB_FOUR  = 2'b01;
   localparam logic [1:0] ALUB_IMM   = 2'b10;
   localparam logic [1:0] ALUB_IMMSH = 2'b11;

   // PC source selects.
   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   // Control word produced per state; pcwrite/branch are combined with the
   // ALU zero flag into pcen at the top level.
   typedef struct packed {
      logic       iord;
      logic       memwrite;
      logic       irwrite;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic       pcwrite;
      logic       branch;
      logic [1:0] aluop;
   } ctrl_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// State -> control-word decode for the multicycle MIPS main control.
// Pure Moore decode apart from the memory-gated strobes in FETCH and MEMWR.
module mips_ctrl_outdec
   import mips_pkg::*;
(
   input  logic [3:0] state,
   input  logic       mem_ready,
   output ctrl_t      ctl
);

   // Default everything to 0, then raise only what each state needs.
   always_comb begin
      ctl = '0;
      case (state)
         S_FETCH: begin
            ctl.iord    = 1'b0;
            ctl.alusrca = 1'b0;
            ctl.alusrcb = ALUB_FOUR;
            ctl.aluop   = ALUOP_ADD;
            ctl.pcsrc   = PC_ALU;
            ctl.irwrite = mem_ready;
            ctl.pcwrite = mem_ready;
         end
         S_DECODE: begin
            ctl.alusrca = 1'b0;
            ctl.alusrcb = ALUB_IMMSH;
            ctl.aluop   = ALUOP_ADD;
         end
         S_MEMADR: begin
            ctl.alusrca = 1'b1;
            ctl.alusrcb = ALUB_IMM;
            ctl.aluop   = ALUOP_ADD;
         end
         S_MEMRD: begin
            ctl.iord = 1'b1;
         end
         S_MEMWB: begin
            ctl.regdst   = 1'b0;
            ctl.memtoreg = 1'b1;
            ctl.regwrite = 1'b1;
         end
         S_MEMWR: begin
            ctl.iord     = 1'b1;
            ctl.memwrite = mem_ready;
         end
         S_RTYPEEX: begin
            ctl.alusrca = 1'b1;
            ctl.alusrcb = ALUB_REG;
            ctl.aluop   = ALUOP_FUNCT;
         end
         S_RTYPEWB: begin
            ctl.regdst   = 1'b1;
            ctl.memtoreg = 1'b0;
            ctl.regwrite = 1'b1;
         end
         S_BEQEX: begin
            ctl.alusrca = 1'b1;
            ctl.alusrcb = ALUB_REG;
            ctl.aluop   = ALUOP_SUB;
            ctl.pcsrc   = PC_ALUOUT;
            ctl.branch  = 1'b1;
         end
         S_ADDIEX: begin
            ctl.alusrca = 1'b1;
            ctl.alusrcb = ALUB_IMM;
            ctl.aluop   = ALUOP_ADD;
         end
         S_ADDIWB: begin
            ctl.regdst   = 1'b0;
            ctl.memtoreg = 1'b0;
            ctl.regwrite = 1'b1;
         end
         S_JEX: begin
            ctl.pcsrc   = PC_JUMP;
            ctl.pcwrite = 1'b1;
         end
         default: begin
            // HALT and unused codes: no datapath activity.
            ctl = '0;
         end
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: sequences each instruction,
// watches the memory handshake with a wait counter and halts on an illegal
// opcode or a memory timeout. Control words come from mips_ctrl_outdec.
//
// Memory handshake: in FETCH, MEMRD and MEMWR the FSM holds its access request
// steady until mem_ready is sampled high on a rising edge; that edge completes
// the access and the FSM moves on. irwrite, pcen (in FETCH) and memwrite are
// qualified by mem_ready, so they strobe only in the completing cycle.
module mips_multicycle_ctrl
   import mips_pkg::*;
#(
   parameter int TMO_W = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic       pcen,
   output logic [1:0] aluop,
   output logic       illegal,
   output logic       mem_tmo,
   output logic [3:0] state_o
);

   // Counter value in the stalled cycle that completes 2**TMO_W-1 stalls.
   localparam logic [TMO_W-1:0] TMO_LAST = {TMO_W{1'b1}} - TMO_W'(1);

   logic [3:0]       state;
   logic [3:0]       state_nx;
   logic [TMO_W-1:0] cnt;
   logic [TMO_W-1:0] cnt_nx;
   logic             waiting;
   logic             set_illegal;
   logic             set_tmo;
   ctrl_t            ctl;

   // Next-state logic, including the timeout override of memory waits.
   always_comb begin
      state_nx    = state;
      waiting     = 1'b0;
      set_illegal = 1'b0;
      set_tmo     = 1'b0;
      case (state)
         S_FETCH: begin
            waiting = 1'b1;
            if (mem_ready) state_nx = S_DECODE;
         end
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_nx = S_MEMADR;
               OP_RTYPE:     state_nx = S_RTYPEEX;
               OP_BEQ:       state_nx = S_BEQEX;
               OP_ADDI:      state_nx = S_ADDIEX;
               OP_J:         state_nx = S_JEX;
               default: begin
                  state_nx    = S_HALT;
                  set_illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR:  state_nx = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD: begin
            waiting = 1'b1;
            if (mem_ready) state_nx = S_MEMWB;
         end
         S_MEMWB:   state_nx = S_FETCH;
         S_MEMWR: begin
            waiting = 1'b1;
            if (mem_ready) state_nx = S_FETCH;
         end
         S_RTYPEEX: state_nx = S_RTYPEWB;
         S_RTYPEWB: state_nx = S_FETCH;
         S_BEQEX:   state_nx = S_FETCH;
         S_ADDIEX:  state_nx = S_ADDIWB;
         S_ADDIWB:  state_nx = S_FETCH;
         S_JEX:     state_nx = S_FETCH;
         default:   state_nx = S_HALT;
      endcase
      // A completing mem_ready in the last allowed cycle takes precedence.
      if (waiting && !mem_ready && (cnt == TMO_LAST)) begin
         state_nx = S_HALT;
         set_tmo  = 1'b1;
      end
   end

   // Wait counter: restart on any state change or completed access, count stalls.
   always_comb begin
      cnt_nx = '0;
      if ((state_nx == state) && waiting && !mem_ready) cnt_nx = cnt + TMO_W'(1);
   end

   // State, wait counter and sticky error flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_FETCH;
         cnt     <= '0;
         illegal <= 1'b0;
         mem_tmo <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         illegal <= illegal | set_illegal;
         mem_tmo <= mem_tmo | set_tmo;
      end
   end

   mips_ctrl_outdec u_outdec (
      .state     (state),
      .mem_ready (mem_ready),
      .ctl       (ctl)
   );

   // Write strobes are held low throughout reset so nothing is written
   // while the FSM sits in FETCH with mem_ready possibly high.
   assign irwrite  = ctl.irwrite & rst_n;
   assign memwrite = ctl.memwrite & rst_n;
   assign regwrite = ctl.regwrite & rst_n;
   assign pcen     = (ctl.pcwrite | (ctl.branch & zero)) & rst_n;

   assign iord     = ctl.iord;
   assign regdst   = ctl.regdst;
   assign memtoreg = ctl.memtoreg;
   assign alusrca  = ctl.alusrca;
   assign alusrcb  = ctl.alusrcb;
   assign pcsrc    = ctl.pcsrc;
   assign aluop    = ctl.aluop;
   assign state_o  = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multicycle MIPS main control. Inputs change on the
// falling edge; outputs are sampled 1 ns later, away from the rising edge.
module tb_mips_multicycle_ctrl;

   // State codes as observed on state_o.
   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_DECODE  = 4'd1;
   localparam logic [3:0] S_MEMADR  = 4'd2;
   localparam logic [3:0] S_MEMRD   = 4'd3;
   localparam logic [3:0] S_MEMWB   = 4'd4;
   localparam logic [3:0] S_MEMWR   = 4'd5;
   localparam logic [3:0] S_RTYPEEX = 4'd6;
   localparam logic [3:0] S_RTYPEWB = 4'd7;
   localparam logic [3:0] S_BEQEX   = 4'd8;
   localparam logic [3:0] S_ADDIEX  = 4'd9;
   localparam logic [3:0] S_ADDIWB  = 4'd10;
   localparam logic [3:0] S_JEX     = 4'd11;
   localparam logic [3:0] S_HALT    = 4'd12;

   // Expected control words, field order:
   // iord_memwrite_irwrite_regdst_memtoreg_regwrite_alusrca_alusrcb_pcsrc_pcen_aluop
   localparam logic [13:0] C_FETCH_RDY  = 14'b0_0_1_0_0_0_0_01_00_1_00;
   localparam logic [13:0] C_FETCH_WAIT = 14'b0_0_0_0_0_0_0_01_00_0_00;
   localparam logic [13:0] C_DECODE     = 14'b0_0_0_0_0_0_0_11_00_0_00;
   localparam logic [13:0] C_MEMADR     = 14'b0_0_0_0_0_0_1_10_00_0_00;
   localparam logic [13:0] C_MEMRD      = 14'b1_0_0_0_0_0_0_00_00_0_00;
   localparam logic [13:0] C_MEMWB      = 14'b0_0_0_0_1_1_0_00_00_0_00;
   localparam logic [13:0] C_MEMWR_WAIT = 14'b1_0_0_0_0_0_0_00_00_0_00;
   localparam logic [13:0] C_MEMWR_GO   = 14'b1_1_0_0_0_0_0_00_00_0_00;
   localparam logic [13:0] C_RTYPEEX    = 14'b0_0_0_0_0_0_1_00_00_0_10;
   localparam logic [13:0] C_RTYPEWB    = 14'b0_0_0_1_0_1_0_00_00_0_00;
   localparam logic [13:0] C_BEQ_TAKEN  = 14'b0_0_0_0_0_0_1_00_01_1_01;
   localparam logic [13:0] C_BEQ_NOT    = 14'b0_0_0_0_0_0_1_00_01_0_01;
   localparam logic [13:0] C_ADDIEX     = 14'b0_0_0_0_0_0_1_10_00_0_00;
   localparam logic [13:0] C_ADDIWB     = 14'b0_0_0_0_0_1_0_00_00_0_00;
   localparam logic [13:0] C_JEX        = 14'b0_0_0_0_0_0_0_00_10_1_00;
   localparam logic [13:0] C_HALT       = 14'b0_0_0_0_0_0_0_00_00_0_00;

   logic       clk;
   logic       rst_n;
   logic [5:0] op;
   logic       zero;
   logic       mem_ready;
   logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
   logic [1:0] alusrcb, pcsrc, aluop;
   logic       illegal, mem_tmo;
   logic [3:0] state_o;
   logic [13:0] ctl_w;

   int n_checks = 0;
   int n_errors = 0;

   mips_multicycle_ctrl #(.TMO_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .op        (op),
      .zero      (zero),
      .mem_ready (mem_ready),
      .iord      (iord),
      .memwrite  (memwrite),
      .irwrite   (irwrite),
      .regdst    (regdst),
      .memtoreg  (memtoreg),
      .regwrite  (regwrite),
      .alusrca   (alusrca),
      .alusrcb   (alusrcb),
      .pcsrc     (pcsrc),
      .pcen      (pcen),
      .aluop     (aluop),
      .illegal   (illegal),
      .mem_tmo   (mem_tmo),
      .state_o   (state_o)
   );

   assign ctl_w = {iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                   alusrca, alusrcb, pcsrc, pcen, aluop};

   // Clock: 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the sequence below ever stalls.
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive inputs, check state and control word, advance.
   task automatic cyc(input string tag, input logic mr, input logic z,
                      input logic [3:0] es, input logic [13:0] ec);
      mem_ready = mr;
      zero      = z;
      #1;
      check({tag, ".state"}, 32'(state_o), 32'(es));
      check({tag, ".ctl"}, 32'(ctl_w), 32'(ec));
      @(negedge clk);
   endtask

   // Reset with mem_ready high: strobes must stay low, flags clear.
   task automatic do_reset(input string tag);
      rst_n     = 1'b0;
      mem_ready = 1'b1;
      #1;
      check({tag, ".state"}, 32'(state_o), 32'(S_FETCH));
      check({tag, ".ctl"}, 32'(ctl_w), 32'(C_FETCH_WAIT));
      check({tag, ".illegal"}, 32'(illegal), 32'd0);
      check({tag, ".mem_tmo"}, 32'(mem_tmo), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      op        = 6'b000000;
      zero      = 1'b0;
      mem_ready = 1'b0;
      do_reset("rst0");

      // lw: five cycles, register write only in MEMWB with memtoreg.
      op = 6'b100011;
      cyc("lw.fetch", 1'b1, 1'b0, S_FETCH, C_FETCH_RDY);
      cyc("lw.decode", 1'b1, 1'b0, S_DECODE, C_DECODE);
      cyc("lw.memadr", 1'b1, 1'b0, S_MEMADR, C_MEMADR);
      cyc("lw.memrd", 1'b1, 1'b0, S_MEMRD, C_MEMRD);
      cyc("lw.memwb", 1'b1, 1'b0, S_MEMWB, C_MEMWB);

      // R-type: four cycles.
      op = 6'b000000;
      cyc("r.fetch", 1'b1, 1'b0, S_FETCH, C_FETCH_RDY);
      cyc("r.decode", 1'b1, 1'b0, S_DECODE, C_DECODE);
      cyc("r.ex", 1'b1, 1'b0, S_RTYPEEX, C_RTYPEEX);
      cyc("r.wb", 1'b1, 1'b0, S_RTYPEWB, C_RTYPEWB);

      // beq taken, then not taken.
      op = 6'b000100;
      cyc("beq1.fetch", 1'b1, 1'b1, S_FETCH, C_FETCH_RDY);
      cyc("beq1.decode", 1'b1, 1'b1, S_DECODE, C_DECODE);
      cyc("beq1.ex", 1'b1, 1'b1, S_BEQEX, C_BEQ_TAKEN);
      cyc("beq0.fetch", 1'b1, 1'b0, S_FETCH, C_FETCH_RDY);
      cyc("beq0.decode", 1'b1, 1'b0, S_DECODE, C_DECODE);
      cyc("beq0.ex", 1'b1, 1'b0, S_BEQEX, C_BEQ_NOT);

      // sw with three stalled cycles in MEMWR; memwrite only in the fourth.
      op = 6'b101011;
      cyc("sw.fetch", 1'b1, 1'b0, S_FETCH, C_FETCH_RDY);
      cyc("sw.decode", 1'b1, 1'b0, S_DECODE, C_DECODE);
      cyc("sw.memadr", 1'b1, 1'b0, S_MEMADR, C_MEMADR);
      for (int i = 0; i < 3; i++) cyc("sw.stall", 1'b0, 1'b0, S_MEMWR, C_MEMWR_WAIT);
      cyc("sw.write", 1'b1, 1'b0, S_MEMWR, C_MEMWR_GO);

      // addi: four cycles.
      op = 6'b001000;
      cyc("addi.fetch", 1'b1, 1'b0, S_FETCH, C_FETCH_RDY);
      cyc("addi.decode", 1'b1, 1'b0, S_DECODE, C_DECODE);
      cyc("addi.ex", 1'b1, 1'b0, S_ADDIEX, C_ADDIEX);
      cyc("addi.wb", 1'b1, 1'b0, S_ADDIWB, C_ADDIWB);

      // j after 14 stalls; mem_ready in the 15th (last allowed) cycle wins.
      op = 6'b000010;
      for (int i = 0; i < 14; i++) cyc("j.stall", 1'b0, 1'b0, S_FETCH, C_FETCH_WAIT);
      cyc("j.fetch_last", 1'b1, 1'b0, S_FETCH, C_FETCH_RDY);
      cyc("j.decode", 1'b1, 1'b0, S_DECODE, C_DECODE);
      cyc("j.ex", 1'b1, 1'b0, S_JEX, C_JEX);
      check("j.mem_tmo", 32'(mem_tmo), 32'd0);

      // Fetch timeout: 15 stalled cycles then HALT with mem_tmo set.
      op = 6'b100011;
      for (int i = 0; i < 15; i++) cyc("tmo.stall", 1'b0, 1'b0, S_FETCH, C_FETCH_WAIT);
      check("tmo.mem_tmo", 32'(mem_tmo), 32'd1);
      check("tmo.illegal", 32'(illegal), 32'd0);
      cyc("tmo.halt", 1'b1, 1'b1, S_HALT, C_HALT);
      cyc("tmo.halt_hold", 1'b1, 1'b0, S_HALT, C_HALT);
      check("tmo.mem_tmo_sticky", 32'(mem_tmo), 32'd1);
      do_reset("rst1");

      // Illegal opcode.
      op = 6'b111111;
      cyc("ill.fetch", 1'b1, 1'b0, S_FETCH, C_FETCH_RDY);
      cyc("ill.decode", 1'b1, 1'b0, S_DECODE, C_DECODE);
      check("ill.illegal", 32'(illegal), 32'd1);
      check("ill.mem_tmo", 32'(mem_tmo), 32'd0);
      cyc("ill.halt", 1'b1, 1'b1, S_HALT, C_HALT);
      cyc("ill.halt_hold", 1'b0, 1'b0, S_HALT, C_HALT);
      do_reset("rst2");

      // Reset pulse in RTYPEEX abandons the instruction: no register write.
      op = 6'b000000;
      cyc("rr.fetch", 1'b1, 1'b0, S_FETCH, C_FETCH_RDY);
      cyc("rr.decode", 1'b1, 1'b0, S_DECODE, C_DECODE);
      mem_ready = 1'b1;
      #1;
      check("rr.ex_state", 32'(state_o), 32'(S_RTYPEEX));
      rst_n = 1'b0;
      #1;
      check("rr.rst_state", 32'(state_o), 32'(S_FETCH));
      check("rr.rst_regwrite", 32'(regwrite), 32'd0);
      check("rr.rst_irwrite", 32'(irwrite), 32'd0);
      check("rr.rst_pcen", 32'(pcen), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc("rr.after", 1'b0, 1'b0, S_FETCH, C_FETCH_WAIT);
      cyc("rr.refetch", 1'b1, 1'b0, S_FETCH, C_FETCH_RDY);
      cyc("rr.redecode", 1'b1, 1'b0, S_DECODE, C_DECODE);
      cyc("rr.reex", 1'b1, 1'b0, S_RTYPEEX, C_RTYPEEX);
      cyc("rr.rewb", 1'b1, 1'b0, S_RTYPEWB, C_RTYPEWB);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
